// File: rtl/ifetch_stage_if.sv
// Fetch-stage bus: pipeline control in, instruction-memory port, and the
// instruction register handed to decode.
interface ifetch_stage_if #(
    parameter int PC_W  = 10,
    parameter int INS_W = 16
);
    logic             stall;
    logic             redirect;
    logic [PC_W-1:0]  redirect_pc;
    logic [PC_W-1:0]  im_addr;
    logic [INS_W-1:0] im_data;
    logic [INS_W-1:0] ir;
    logic [PC_W-1:0]  ir_pc;
    logic             ir_valid;
    logic             halted;

    // Fetch stage side
    modport master (
        input  stall, redirect, redirect_pc, im_data,
        output im_addr, ir, ir_pc, ir_valid, halted
    );

    // Environment side: pipeline control, instruction memory and decode
    modport slave (
        output stall, redirect, redirect_pc, im_data,
        input  im_addr, ir, ir_pc, ir_valid, halted
    );
endinterface

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: PC register, instruction register, BOOT/RUN(/HALT) FSM.
// Optional FETCH_HALT_EN: an all-zero instruction word halts fetch until reset.
module ifetch_stage #(
    parameter int              PC_W     = 10,
    parameter int              INS_W    = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    ifetch_stage_if.master bus
);
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t           r_state;
    logic [PC_W-1:0]  r_pc;
    logic [INS_W-1:0] r_ir;
    logic [PC_W-1:0]  r_ir_pc;
    logic             r_ir_valid;
    logic             r_halted;
    logic             w_zero_word;

    assign w_zero_word = (bus.im_data == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= BOOT;
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_ir_pc    <= '0;
            r_ir_valid <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                BOOT: begin
                    // One bubble after reset; a redirect here still lands in RUN.
                    if (bus.redirect) begin
                        r_pc <= bus.redirect_pc;
                    end
                    r_ir_valid <= 1'b0;
                    r_state    <= RUN;
                end
                RUN: begin
                    if (bus.redirect) begin
                        r_pc       <= bus.redirect_pc;
                        r_ir_valid <= 1'b0;
                    end else if (bus.stall) begin
                        r_pc       <= r_pc;
                    end
`ifdef FETCH_HALT_EN
                    else if (w_zero_word) begin
                        r_ir_valid <= 1'b0;
                        r_halted   <= 1'b1;
                        r_state    <= HALT;
                    end
`endif
                    else begin
                        r_ir       <= bus.im_data;
                        r_ir_pc    <= r_pc;
                        r_ir_valid <= 1'b1;
                        r_pc       <= r_pc + PC_W'(1);
                    end
                end
                HALT: begin
                    // Only reset leaves HALT.
                    r_ir_valid <= 1'b0;
                    r_halted   <= 1'b1;
                end
                default: begin
                    r_state <= BOOT;
                end
            endcase
        end
    end

    assign bus.im_addr  = r_pc;
    assign bus.ir       = r_ir;
    assign bus.ir_pc    = r_ir_pc;
    assign bus.ir_valid = r_ir_valid;
`ifdef FETCH_HALT_EN
    assign bus.halted   = r_halted;
`else
    assign bus.halted   = 1'b0;
    logic w_unused;
    assign w_unused     = r_halted ^ w_zero_word;
`endif
endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: boot bubble, stall, redirect, wrap,
// asynchronous reset, and the optional halt-on-zero-word behaviour.
module tb_ifetch_stage;
    localparam int PC_W  = 10;
    localparam int INS_W = 16;

    logic clk;
    logic rst;
    logic [INS_W-1:0] mem [0:(1<<PC_W)-1];

    int n_checks;
    int n_fail;

    ifetch_stage_if #(.PC_W(PC_W), .INS_W(INS_W)) bus ();

    ifetch_stage #(.PC_W(PC_W), .INS_W(INS_W), .RESET_PC('0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.im_data = mem[bus.im_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < (1 << PC_W); i++) mem[i] = INS_W'(16'h4000 | i);
        mem[0] = 16'h8080;
        mem[1] = 16'h8504;
        mem[2] = 16'h080A;

        rst             = 1'b0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;

        step();
        step();
        chk("rst_im_addr",  32'(bus.im_addr),  32'd0);
        chk("rst_ir",       32'(bus.ir),       32'd0);
        chk("rst_ir_pc",    32'(bus.ir_pc),    32'd0);
        chk("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
        chk("rst_halted",   32'(bus.halted),   32'd0);

        rst = 1'b1;
        step();
        chk("boot_ir_valid", 32'(bus.ir_valid), 32'd0);
        chk("boot_im_addr",  32'(bus.im_addr),  32'd0);
        step();
        chk("f0_ir",    32'(bus.ir),       32'h8080);
        chk("f0_ir_pc", 32'(bus.ir_pc),    32'd0);
        chk("f0_valid", 32'(bus.ir_valid), 32'd1);
        step();
        chk("f1_ir",    32'(bus.ir),    32'h8504);
        chk("f1_ir_pc", 32'(bus.ir_pc), 32'd1);

        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_ir",      32'(bus.ir),      32'h8504);
            chk("stall_ir_pc",   32'(bus.ir_pc),   32'd1);
            chk("stall_im_addr", 32'(bus.im_addr), 32'd2);
        end
        bus.stall = 1'b0;
        step();
        chk("f2_ir",    32'(bus.ir),    32'h080A);
        chk("f2_ir_pc", 32'(bus.ir_pc), 32'd2);
        step();
        step();
        chk("pc5_im_addr", 32'(bus.im_addr), 32'd5);

        // Redirect beats a concurrent stall.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 10'd20;
        bus.stall       = 1'b1;
        step();
        bus.redirect = 1'b0;
        bus.stall    = 1'b0;
        chk("redir_im_addr",  32'(bus.im_addr),  32'd20);
        chk("redir_ir_valid", 32'(bus.ir_valid), 32'd0);
        chk("redir_ir_pc",    32'(bus.ir_pc),    32'd4);
        step();
        chk("redir_ir",       32'(bus.ir),       32'(16'h4000 | 20));
        chk("redir_ir_pc2",   32'(bus.ir_pc),    32'd20);
        chk("redir_valid2",   32'(bus.ir_valid), 32'd1);

        // Stall during the flush bubble keeps the bubble.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 10'd100;
        step();
        bus.redirect = 1'b0;
        bus.stall    = 1'b1;
        step();
        step();
        chk("bubble_valid",   32'(bus.ir_valid), 32'd0);
        chk("bubble_im_addr", 32'(bus.im_addr),  32'd100);
        bus.stall = 1'b0;
        step();
        chk("bubble_ir_pc",   32'(bus.ir_pc),    32'd100);

        // PC wrap 1023 -> 0.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 10'd1023;
        step();
        bus.redirect = 1'b0;
        step();
        chk("wrap_im_addr", 32'(bus.im_addr), 32'd0);
        chk("wrap_ir_pc",   32'(bus.ir_pc),   32'd1023);
        chk("wrap_ir",      32'(bus.ir),      32'(16'h4000 | 1023));
        step();
        chk("wrap_next_pc", 32'(bus.ir_pc),   32'd0);

        // Asynchronous reset mid-stream.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 10'd9;
        step();
        bus.redirect = 1'b0;
        chk("pc9_im_addr", 32'(bus.im_addr), 32'd9);
        step();
        #2 rst = 1'b0;
        #1;
        chk("arst_im_addr",  32'(bus.im_addr),  32'd0);
        chk("arst_ir",       32'(bus.ir),       32'd0);
        chk("arst_ir_pc",    32'(bus.ir_pc),    32'd0);
        chk("arst_ir_valid", 32'(bus.ir_valid), 32'd0);
        step();
        rst = 1'b1;
        step();
        chk("arst_boot_valid", 32'(bus.ir_valid), 32'd0);
        chk("arst_boot_addr",  32'(bus.im_addr),  32'd0);
        step();
        chk("arst_f0_ir",      32'(bus.ir),       32'h8080);
        chk("arst_f0_pc",      32'(bus.ir_pc),    32'd0);

        // Redirect during BOOT.
        rst = 1'b0;
        step();
        rst = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 10'd50;
        step();
        bus.redirect = 1'b0;
        chk("bootredir_addr",  32'(bus.im_addr),  32'd50);
        chk("bootredir_valid", 32'(bus.ir_valid), 32'd0);
        step();
        chk("bootredir_ir_pc", 32'(bus.ir_pc),    32'd50);
        chk("bootredir_ir",    32'(bus.ir),       32'(16'h4000 | 50));

`ifdef FETCH_HALT_EN
        mem[23]         = '0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 10'd21;
        step();
        bus.redirect = 1'b0;
        step();
        step();
        chk("pre_halt_ir_pc", 32'(bus.ir_pc),   32'd22);
        chk("pre_halt_addr",  32'(bus.im_addr), 32'd23);
        step();
        chk("halt_halted",   32'(bus.halted),   32'd1);
        chk("halt_valid",    32'(bus.ir_valid), 32'd0);
        chk("halt_im_addr",  32'(bus.im_addr),  32'd23);
        chk("halt_ir_pc",    32'(bus.ir_pc),    32'd22);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 10'd0;
        step();
        step();
        bus.redirect = 1'b0;
        chk("halt_redir_addr", 32'(bus.im_addr), 32'd23);
        chk("halt_redir_hlt",  32'(bus.halted),  32'd1);
        rst = 1'b0;
        #1;
        chk("halt_rst_halted", 32'(bus.halted),  32'd0);
        step();
        rst = 1'b1;
`else
        mem[30]         = '0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 10'd30;
        step();
        bus.redirect = 1'b0;
        step();
        chk("zero_ir",     32'(bus.ir),       32'd0);
        chk("zero_ir_pc",  32'(bus.ir_pc),    32'd30);
        chk("zero_valid",  32'(bus.ir_valid), 32'd1);
        chk("zero_halted", 32'(bus.halted),   32'd0);
        chk("zero_addr",   32'(bus.im_addr),  32'd31);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
